// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler for a 1-to-8 demux: one-entry holding register that
// steers each accepted word to the next enabled channel with per-channel valid/ready.
module demux_rr_scheduler #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        ch_en,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_valid,
  input  logic [7:0]        out_ready,
  output logic [2:0]        sel,
  output logic [2:0]        ptr,
  output logic [CNT_W-1:0]  sent_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_data;
  logic [7:0]        r_out_valid;
  logic [2:0]        r_sel;
  logic [2:0]        r_ptr;
  logic [CNT_W-1:0]  r_cnt;

  logic       w_done;
  logic       w_accept;
  logic [2:0] w_start;
  logic [2:0] w_idx;
  logic [2:0] w_tgt;
  logic       w_hit;

  assign w_done   = (r_state == FULL) && out_ready[r_sel];
  assign in_ready = (ch_en != 8'd0) && ((r_state == EMPTY) || w_done);
  assign w_accept = in_valid && in_ready;

  // An accept while FULL implies done, so the search continues past the held target.
  assign w_start  = (r_state == FULL) ? (r_sel + 3'd1) : r_ptr;

  always_comb begin
    w_tgt = w_start;
    w_hit = 1'b0;
    w_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      w_idx = w_start + 3'(i);
      if (!w_hit && ch_en[w_idx]) begin
        w_tgt = w_idx;
        w_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_data      <= '0;
      r_out_valid <= 8'd0;
      r_sel       <= 3'd0;
      r_ptr       <= 3'd0;
      r_cnt       <= '0;
    end else begin
      if (w_done) begin
        r_ptr <= r_sel + 3'd1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_state     <= FULL;
        r_data      <= in_data;
        r_sel       <= w_tgt;
        r_out_valid <= 8'd1 << w_tgt;
      end else if (w_done) begin
        r_state     <= EMPTY;
        r_out_valid <= 8'd0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_out_valid;
  assign sel       = r_sel;
  assign ptr       = r_ptr;
  assign sent_cnt  = r_cnt;

endmodule
